// File: rtl/eaglesong_bit_matrix_step.sv
// Bit-serial Eaglesong bit-matrix step: out_word[j] = XOR_k (in_word[k] & M[16k+j]).
// Requests one matrix bit per cycle from an external lookup and accumulates 256 terms per state.
module eaglesong_bit_matrix_step #(
  parameter int WORD_W  = 32,
  parameter int N_WORDS = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORD_W*N_WORDS-1:0] in_state,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_W*N_WORDS-1:0] out_state,
  output logic [7:0]                bit_index_to_request,
  input  logic                      requested_bit
);

  localparam int CW = $clog2(N_WORDS);
  localparam logic [CW-1:0] LAST = CW'(N_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             k_q, k_d;
  logic [CW-1:0]             j_q, j_d;
  logic [WORD_W-1:0]         acc_q, acc_d;
  logic [WORD_W*N_WORDS-1:0] in_reg_q;
  logic [WORD_W*N_WORDS-1:0] out_reg_q;

  logic              capture;
  logic              word_wr;
  logic [WORD_W-1:0] in_word;
  logic [WORD_W-1:0] acc_next;

  assign in_word  = in_reg_q[k_q*WORD_W +: WORD_W];
  assign acc_next = acc_q ^ (requested_bit ? in_word : '0);

  // k is the inner loop, so one output word is finished every N_WORDS cycles.
  always_comb begin
    state_d              = state_q;
    k_d                  = k_q;
    j_d                  = j_q;
    acc_d                = acc_q;
    in_ready             = 1'b0;
    out_valid            = 1'b0;
    bit_index_to_request = '0;
    capture              = 1'b0;
    word_wr              = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          capture = 1'b1;
          k_d     = '0;
          j_d     = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        bit_index_to_request = 8'({k_q, j_q});
        if (k_q == LAST) begin
          word_wr = 1'b1;
          acc_d   = '0;
          k_d     = '0;
          j_d     = j_q + 1'b1;
          if (j_q == LAST) state_d = DONE;
        end else begin
          acc_d = acc_next;
          k_d   = k_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The result is masked outside DONE so partially rewritten words never leak out.
  assign out_state = out_valid ? out_reg_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      j_q       <= '0;
      acc_q     <= '0;
      in_reg_q  <= '0;
      out_reg_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      if (capture) in_reg_q <= in_state;
      if (word_wr) out_reg_q[j_q*WORD_W +: WORD_W] <= acc_next;
    end
  end

endmodule

// File: tb/tb_eaglesong_bit_matrix_step.sv
// Self-checking bench for eaglesong_bit_matrix_step: vector table, backpressure,
// mid-run reset and randomized states against a direct XOR-sum matrix model.
module tb_eaglesong_bit_matrix_step;

  // Row k holds M[16k+j] at bit j; M[0]=M[2]=1 and M[253]=0 by construction.
  localparam logic [255:0] MATRIX = {
    16'h9F35, 16'h67B9, 16'hB1C4, 16'h2E58, 16'hF0A3, 16'h4D19, 16'h96E2, 16'h0B7C,
    16'hC46D, 16'h38F1, 16'h5AA6, 16'hE307, 16'h1C9E, 16'h7A4B, 16'hD135, 16'h8F5D
  };

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [511:0] in_state = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [511:0] out_state;
  logic [7:0]   bit_index_to_request;
  logic         requested_bit;

  logic [255:0] matrixBits = MATRIX;
  int           total = 0;
  int           bad = 0;
  logic [7:0]   idxLog[$];

  typedef struct {
    string        name;
    logic [511:0] stimulus;
    logic [511:0] expected;
  } vector_t;

  vector_t vectors[6];

  eaglesong_bit_matrix_step #(.WORD_W(32), .N_WORDS(16)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .in_state             (in_state),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_state            (out_state),
    .bit_index_to_request (bit_index_to_request),
    .requested_bit        (requested_bit)
  );

  always #5 clk = ~clk;

  assign requested_bit = matrixBits[bit_index_to_request];

  function automatic logic [511:0] refModel(input logic [511:0] s);
    logic [511:0] r;
    r = '0;
    for (int j = 0; j < 16; j++)
      for (int k = 0; k < 16; k++)
        if (matrixBits[16*k + j]) r[32*j +: 32] = r[32*j +: 32] ^ s[32*k +: 32];
    return r;
  endfunction

  function automatic logic [511:0] randState();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Accepts one state after 'gap' idle cycles and returns the edge count (acceptance edge included) until out_valid.
  task automatic applyStimulus(input logic [511:0] st, input int gap, output int lat);
    int n;
    repeat (gap) begin @(posedge clk); #1; end
    n = 0;
    while (!in_ready && n < 600) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      checkOutput("accept_timeout", 512'(in_ready), 512'(1));
      lat = 0;
      return;
    end
    in_valid = 1'b1;
    in_state = st;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_state = randState();
    lat = 1;
    idxLog.delete();
    while (!out_valid && lat < 400) begin
      idxLog.push_back(bit_index_to_request);
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("latency", 512'(lat), 512'(257));
  endtask

  // Holds out_ready low for 'delay' cycles (optionally offering a new input), then completes the handshake.
  task automatic collectOutput(input string name, input logic [511:0] exp, input int delay, input bit poke);
    logic [511:0] snap;
    snap = out_state;
    if (poke) begin
      in_valid = 1'b1;
      in_state = randState();
    end
    for (int i = 0; i < delay; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_flags", 512'({out_valid, in_ready}), 512'(2'b10));
      checkOutput("hold_data", out_state, snap);
    end
    in_valid = 1'b0;
    checkOutput(name, snap, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("after_handshake", 512'({out_valid, in_ready}), 512'(2'b01));
  endtask

  initial begin
    int           lat;
    int           done;
    bit           seqOk;
    logic [511:0] st;
    logic [511:0] word0;
    logic [511:0] word15;

    word0  = '0;
    word0[31:0] = 32'hDEADBEEF;
    word15 = '0;
    word15[511:480] = 32'hFFFFFFFF;

    vectors[0] = '{"zero",        '0,       '0};
    vectors[1] = '{"word0_beef",  word0,    refModel(word0)};
    vectors[2] = '{"word15_ones", word15,   refModel(word15)};
    vectors[3] = '{"all_ones",    '1,       refModel('1)};
    st = {16{32'hA5A5_5A5A}};
    vectors[4] = '{"pattern",     st,       refModel(st)};
    for (int i = 0; i < 16; i++) st[32*i +: 32] = 32'(1) << (2 * i);
    vectors[5] = '{"walking_bit", st,       refModel(st)};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_flags", 512'({in_ready, out_valid}), 512'(2'b10));
    checkOutput("reset_state", out_state, '0);
    checkOutput("reset_index", 512'(bit_index_to_request), '0);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vectors[v].stimulus, 1, lat);
      if (v == 0) begin
        seqOk = (idxLog.size() == 256);
        for (int i = 0; i < idxLog.size(); i++)
          if (idxLog[i] !== 8'(((i % 16) << 4) | (i / 16))) seqOk = 1'b0;
        checkOutput("index_sequence", 512'(seqOk), 512'(1));
      end
      if (v == 1) begin
        checkOutput("beef_word0", 512'(out_state[31:0]), 512'(32'hDEADBEEF));
        checkOutput("beef_word2", 512'(out_state[95:64]), 512'(32'hDEADBEEF));
      end
      if (v == 2) checkOutput("ones_word13", 512'(out_state[447:416]), '0);
      collectOutput(vectors[v].name, vectors[v].expected, 0, 1'b0);
    end

    st = randState();
    applyStimulus(st, 0, lat);
    collectOutput("backpressure", refModel(st), 10, 1'b1);
    st = randState();
    applyStimulus(st, 0, lat);
    collectOutput("after_backpressure", refModel(st), 0, 1'b0);

    in_valid = 1'b1;
    in_state = randState();
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrun_reset_flags", 512'({in_ready, out_valid}), 512'(2'b10));
    checkOutput("midrun_reset_state", out_state, '0);
    checkOutput("midrun_reset_index", 512'(bit_index_to_request), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    st = randState();
    applyStimulus(st, 1, lat);
    collectOutput("after_reset", refModel(st), 0, 1'b0);

    done = 0;
    for (int n = 0; n < 50; n++) begin
      st = randState();
      applyStimulus(st, int'($urandom_range(0, 3)), lat);
      collectOutput("random", refModel(st), int'($urandom_range(0, 4)), 1'b0);
      done++;
    end
    checkOutput("random_count", 512'(done), 512'(50));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eaglesong_bit_matrix_step.md
# eaglesong_bit_matrix_step

Sequential engine for the Eaglesong bit-matrix step: out_word[j] = XOR over k of (in_word[k] AND M[16k+j]) across the 16 32-bit state words. Acts as the requesting side of the eaglesong_bit_matrix lookup port, driving one bit index per cycle and consuming the returned bit. Sits in the permutation round datapath between the state register and the circulant-multiplication step. Trades area for latency: one 16x16 matrix bit per cycle, 256 compute cycles per state.

## Interface

Parameters
- WORD_W, 32, width of one state word
- N_WORDS, 16, state words per permutation state; matrix is N_WORDS x N_WORDS

Ports
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_state holds a state to process
- in_ready  output  1  engine accepts a state this cycle
- in_state  input  512  word i at bits [32i+31:32i]
- out_valid  output  1  out_state holds a finished result
- out_ready  input  1  downstream accepts the result
- out_state  output  512  result, same word packing as in_state
- bit_index_to_request  output  8  matrix index {k[3:0], j[3:0]} = 16k+j, to eaglesong_bit_matrix
- requested_bit  input  1  M[bit_index_to_request], combinational same-cycle return

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid, capture in_state into in_reg, clear k, j and acc, go to RUN.
- RUN: bit_index_to_request = {k,j}. acc_next = acc ^ (requested_bit ? in_reg[k] : 0).
  - k<15: acc<=acc_next, k<=k+1.
  - k==15: out_reg[j]<=acc_next, acc<=0, k<=0, j<=j+1; if j==15, go to DONE.
- DONE: out_valid=1, out_state=out_reg. On out_ready, go to IDLE.
- in_ready=1 only in IDLE; out_valid=1 only in DONE. No overlap between input and output transactions.
- bit_index_to_request = 0 in IDLE and DONE.
- k and j are 4-bit counters, wrapping 15->0. XOR only, no carries.
- out_reg words not yet written in the current run keep their previous values. They are not visible externally until DONE.
- in_state changes after acceptance have no effect, since in_reg is captured.

## Timing

- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, out_state=0, bit_index_to_request=0, and k, j, acc and in_reg cleared.
- Acceptance edge E0 (in_valid & in_ready). RUN occupies the 256 cycles after E0.
- out_valid rises 257 edges after E0, and stays high with out_state stable until the out_ready handshake edge.
- With out_ready held high, out_valid lasts exactly 1 cycle. The next accept is possible 1 cycle later (IDLE).
- Minimum acceptance-to-acceptance interval: 258 cycles.
- Reset asserted mid-RUN or in DONE aborts the operation. The result is lost, outputs return to reset values, and the next acceptance starts a fresh run.
- requested_bit is sampled in the same cycle as its index. There is no pipeline stage between the index and the bit.

## Test plan

- All-zero in_state -> after 257 cycles out_valid=1, out_state all zero. bit_index_to_request steps 0x00,0x10,...,0xF0,0x01,... during RUN.
- in_word[0]=0xDEADBEEF, other words 0 -> out_word[j]=0xDEADBEEF iff M[j]=1, else 0. Concretely out_word[0]=out_word[2]=0xDEADBEEF, matching M[0]=M[2]=1.
- in_word[15]=0xFFFFFFFF, other words 0 -> out_word[13] (index 253, M=0) is 0x00000000. Every other word equals M[240+j] replicated.
- Backpressure: out_ready held low 10 cycles after out_valid -> out_valid stays 1 and out_state stays unchanged. in_ready stays 0 and a new in_valid is ignored. After out_ready, the next state is accepted one cycle later.
- rst_n pulsed low at cycle 100 of RUN -> out_valid=0, out_state=0 and in_ready=1 immediately. A new state then yields the correct result 257 edges after its acceptance.
- 50 random states with random in_valid/out_ready gaps, checked against a behavioural XOR reference model -> all results match. No input is dropped or duplicated.
